// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a FWFT byte FIFO
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH        = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     rx,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frame_err,
    output logic                     overrun,
    output logic                     parity_err,
    input  logic                     clear_err
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [15:0] HALF_BIT  = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] FULL_BIT  = 16'(CLKS_PER_BIT);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4,
        S_PARITY    = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;
`endif

    // ---------------------------------------------------------------
    // Line synchronizer; flops reset to the idle (high) level so a
    // reset never looks like a falling edge.
    // ---------------------------------------------------------------
    logic rx_meta_q;
    logic rx_sync_q;

    // Two-flop synchronizer for the asynchronous rx pin
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // ---------------------------------------------------------------
    // Receive FSM and bit-timing datapath
    // ---------------------------------------------------------------
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        push_q, push_d;
    logic        frame_set;
    logic        parity_set;
    logic        expire;

`ifdef UART_RX_PARITY_EN
    logic        par_bad_q, par_bad_d;
`endif

    // The bit counter counts down; the last cycle of a bit period is
    // the sample point, which is mid-bit thanks to the half-period load.
    assign expire = (cnt_q == 16'd1);

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            push_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            push_q    <= push_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != 16'd0) ? cnt_q - 16'd1 : 16'd0;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_sync_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_BIT;
                end
            end
            S_START: begin
                if (expire) begin
                    if (!rx_sync_q) begin
                        state_d = S_DATA;
                        cnt_d   = FULL_BIT;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (expire) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    cnt_d   = FULL_BIT;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (expire) begin
                    par_bad_d = ^{shift_q, rx_sync_q};
                    cnt_d     = FULL_BIT;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (expire) begin
                    state_d = rx_sync_q ? S_IDLE : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (rx_sync_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: push request (acted on next cycle) and error flag sets
    always_comb begin
        push_d     = 1'b0;
        frame_set  = 1'b0;
        parity_set = 1'b0;
        case (state_q)
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (expire) begin
                    parity_set = ^{shift_q, rx_sync_q};
                end
            end
`endif
            S_STOP: begin
                if (expire) begin
                    if (rx_sync_q) begin
`ifdef UART_RX_PARITY_EN
                        push_d = !par_bad_q;
`else
                        push_d = 1'b1;
`endif
                    end else begin
                        frame_set = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // First-word-fall-through FIFO
    // ---------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full;
    logic          pop;
    logic          wr_en;
    logic          ovf_set;

    assign full      = (count_q == DEPTH_CNT);
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO
    // still lands when the head is leaving in the same cycle.
    assign wr_en     = push_q & (~full | pop);
    assign ovf_set   = push_q & full & ~pop;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign count     = count_q;

    // Occupancy next value
    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset since out_data is masked when empty
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // ---------------------------------------------------------------
    // Sticky status flags; a set in the same cycle as clear_err wins
    // ---------------------------------------------------------------
    logic frame_err_q;
    logic overrun_q;

    // Frame and overrun sticky flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_set | (frame_err_q & ~clear_err);
            overrun_q   <= ovf_set   | (overrun_q   & ~clear_err);
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;

    // Parity sticky flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_set | (parity_err_q & ~clear_err);
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
    logic unused_parity;
    assign unused_parity = parity_set;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo (CLKS_PER_BIT=16, DEPTH=4)
module tb_uart_rx_fifo;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Edge (counted from the start-bit edge) on which the FIFO write lands
    localparam int PUSH_EDGE = 156 + CPB * (NB - 10);

    logic       clk;
    logic       rst;
    logic       rx;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] count;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic       clear_err;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(4)) dut (
        .CLK        (clk),
        .RST        (rst),
        .rx         (rx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .count      (count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .clear_err  (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One frame, LSB first; par_flip inverts the (even) parity bit when present
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_flip);
        logic [10:0] bits;
        bits = {1'b1, stop_bit, data, 1'b0};
`ifdef UART_RX_PARITY_EN
        bits = {stop_bit, (^data) ^ par_flip, data, 1'b0};
`endif
        @(posedge clk);
        #1;
        for (int i = 0; i < NB; i++) begin
            rx = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        idle(20);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        @(negedge clk);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic clear_pulse();
        @(posedge clk);
        #1;
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        out_ready = 1'b0;
        clear_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_data", out_data, 8'h00);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_perr", parity_err, 0);

        // Single byte, consumer stalled
        send_frame(8'hA5, 1'b1, 1'b0);
        @(negedge clk);
        chk("a5_valid", out_valid, 1);
        chk("a5_data", out_data, 8'hA5);
        chk("a5_count", count, 1);
        chk("a5_ferr", frame_err, 0);
        chk("a5_ovr", overrun, 0);
        pop_chk("a5_pop", 8'hA5);
        @(negedge clk);
        chk("a5_empty", count, 0);

        // Short low glitch is rejected silently
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        idle(40);
        @(negedge clk);
        chk("glitch_count", count, 0);
        chk("glitch_ferr", frame_err, 0);

        // Bit order check with an asymmetric byte
        send_frame(8'h2D, 1'b1, 1'b0);
        pop_chk("b2d", 8'h2D);

        // Framing error, then recovery after line returns high
        send_frame(8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        chk("ferr_count", count, 0);
        chk("ferr_set", frame_err, 1);
        clear_pulse();
        @(negedge clk);
        chk("ferr_clr", frame_err, 0);
        send_frame(8'hB1, 1'b1, 1'b0);
        pop_chk("ferr_recover", 8'hB1);

        // Five bytes into a 4-deep FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
        @(negedge clk);
        chk("ovr_count", count, 4);
        chk("ovr_set", overrun, 1);
        for (int i = 1; i <= 4; i++) pop_chk("ovr_pop", 8'(i));
        @(negedge clk);
        chk("ovr_empty", count, 0);
        chk("ovr_valid", out_valid, 0);
        clear_pulse();
        @(negedge clk);
        chk("ovr_clr", overrun, 0);

        // Full FIFO with a pop exactly in the push cycle
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0);
        send_frame(8'h44, 1'b1, 1'b0);
        @(negedge clk);
        chk("full_count", count, 4);
        fork
            send_frame(8'h55, 1'b1, 1'b0);
            begin
                @(posedge clk);
                #1;
                repeat (PUSH_EDGE - 1) @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                out_ready = 1'b0;
            end
        join
        @(negedge clk);
        chk("pp_count", count, 4);
        chk("pp_ovr", overrun, 0);
        pop_chk("pp_pop", 8'h22);
        pop_chk("pp_pop", 8'h33);
        pop_chk("pp_pop", 8'h44);
        pop_chk("pp_pop", 8'h55);
        @(negedge clk);
        chk("pp_empty", count, 0);

`ifdef UART_RX_PARITY_EN
        // Bad then good parity on 0x07 (three ones -> parity bit 1)
        send_frame(8'h07, 1'b1, 1'b1);
        @(negedge clk);
        chk("par_bad_flag", parity_err, 1);
        chk("par_bad_count", count, 0);
        clear_pulse();
        @(negedge clk);
        chk("par_clr", parity_err, 0);
        send_frame(8'h07, 1'b1, 1'b0);
        @(negedge clk);
        chk("par_good_flag", parity_err, 0);
        pop_chk("par_good", 8'h07);
`endif

        // Reset in the middle of a frame while one byte is buffered
        send_frame(8'h6E, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        #1;
        rx = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3 * CPB);
        @(negedge clk);
        chk("mrst_count", count, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_ferr", frame_err, 0);
        send_frame(8'hC3, 1'b1, 1'b0);
        @(negedge clk);
        chk("mrst_after_count", count, 1);
        pop_chk("mrst_after", 8'hC3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
